// File: rtl/prog_mem_responder.sv
// Program memory for the TTM4 emulator, with a 1-cycle registered read port and a valid/ready host loader.
// Optional: define PROGMEM_CHKSUM_EN to add the LD_CHKSUM output.
module prog_mem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] PA,
  input  logic              nPC_OPEN,
  output logic [DATA_W-1:0] INSTR,
  output logic              INSTR_VALID,
  input  logic              LD_START,
  input  logic [DATA_W-1:0] LD_DATA,
  input  logic              LD_VALID,
  input  logic              LD_LAST,
  output logic              LD_READY,
  output logic              LD_DONE,
  output logic [ADDR_W:0]   LD_COUNT,
  output logic              BUSY
`ifdef PROGMEM_CHKSUM_EN
  ,
  output logic [DATA_W-1:0] LD_CHKSUM
`endif
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_RUN,
    ST_LOAD
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              ld_ready_q, ld_ready_d;
  logic              ld_done_q, ld_done_d;
  logic [CNT_W-1:0]  ld_count_q, ld_count_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
`ifdef PROGMEM_CHKSUM_EN
  logic [DATA_W-1:0] chksum_q, chksum_d;
`endif

  logic xfer;
  logic last_xfer;
  logic mem_we;

  // A restart pulse wins over a byte offered in the same cycle, so the byte is dropped.
  assign xfer      = (state_q == ST_LOAD) && !LD_START && LD_VALID && ld_ready_q;
  assign last_xfer = xfer && (LD_LAST || (ptr_q == {ADDR_W{1'b1}}));
  assign mem_we    = xfer && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (LD_START) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (last_xfer) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    ld_done_d     = 1'b0;
    ld_count_d    = ld_count_q;
    ptr_d         = ptr_q;
    ld_ready_d    = (state_d == ST_LOAD);
`ifdef PROGMEM_CHKSUM_EN
    chksum_d      = chksum_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (LD_START) begin
          ptr_d      = '0;
          ld_count_d = '0;
`ifdef PROGMEM_CHKSUM_EN
          chksum_d   = '0;
`endif
        end else if (!nPC_OPEN) begin
          instr_d       = mem[PA];
          instr_valid_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (LD_START) begin
          ptr_d      = '0;
          ld_count_d = '0;
`ifdef PROGMEM_CHKSUM_EN
          chksum_d   = '0;
`endif
        end else if (xfer) begin
          ld_count_d = ld_count_q + CNT_W'(1);
`ifdef PROGMEM_CHKSUM_EN
          chksum_d   = chksum_q + LD_DATA;
`endif
          // The pointer stops at the last entry instead of wrapping back to 0.
          if (last_xfer) begin
            ld_done_d = 1'b1;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      ld_ready_q    <= 1'b0;
      ld_done_q     <= 1'b0;
      ld_count_q    <= '0;
      ptr_q         <= '0;
`ifdef PROGMEM_CHKSUM_EN
      chksum_q      <= '0;
`endif
    end else begin
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      ld_ready_q    <= ld_ready_d;
      ld_done_q     <= ld_done_d;
      ld_count_q    <= ld_count_d;
      ptr_q         <= ptr_d;
`ifdef PROGMEM_CHKSUM_EN
      chksum_q      <= chksum_d;
`endif
    end
  end

  // The array has no reset, so a loaded program survives RST.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[ptr_q] <= LD_DATA;
    end
  end

  assign INSTR       = instr_q;
  assign INSTR_VALID = instr_valid_q;
  assign LD_READY    = ld_ready_q;
  assign LD_DONE     = ld_done_q;
  assign LD_COUNT    = ld_count_q;
  assign BUSY        = (state_q == ST_LOAD);
`ifdef PROGMEM_CHKSUM_EN
  assign LD_CHKSUM   = chksum_q;
`endif

endmodule

// File: tb/tb_prog_mem_responder.sv
// Self-checking bench for prog_mem_responder: random loads and reads compared against
// an array-based reference model of program memory.
module tb_prog_mem_responder;

   logic       CLK;
   logic       RST;
   logic [7:0] PA;
   logic       nPC_OPEN;
   logic [7:0] INSTR;
   logic       INSTR_VALID;
   logic       LD_START;
   logic [7:0] LD_DATA;
   logic       LD_VALID;
   logic       LD_LAST;
   logic       LD_READY;
   logic       LD_DONE;
   logic [8:0] LD_COUNT;
   logic       BUSY;
`ifdef PROGMEM_CHKSUM_EN
   logic [7:0] LD_CHKSUM;
`endif

   // Reference model: memory image plus the expected registered read outputs
   logic [7:0] modelMem [256];
   logic [7:0] modelInstr;
   logic       modelValid;
   logic [7:0] loadQ [$];
   int         numCompared;
   int         numMismatched;

   prog_mem_responder #(.ADDR_W(8), .DATA_W(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .PA         (PA),
      .nPC_OPEN   (nPC_OPEN),
      .INSTR      (INSTR),
      .INSTR_VALID(INSTR_VALID),
      .LD_START   (LD_START),
      .LD_DATA    (LD_DATA),
      .LD_VALID   (LD_VALID),
      .LD_LAST    (LD_LAST),
      .LD_READY   (LD_READY),
      .LD_DONE    (LD_DONE),
      .LD_COUNT   (LD_COUNT),
      .BUSY       (BUSY)
`ifdef PROGMEM_CHKSUM_EN
      ,
      .LD_CHKSUM  (LD_CHKSUM)
`endif
   );

   // Free-running 10-time-unit clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Advance one clock and settle just past the rising edge before sampling
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Single comparison point: counts every check and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      numCompared++;
      if (actual !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Drive every non-reset input in one go
   task automatic applyStimulus(input logic start, input logic valid, input logic [7:0] data,
                                input logic last, input logic npc, input logic [7:0] pa);
      LD_START = start;
      LD_VALID = valid;
      LD_DATA  = data;
      LD_LAST  = last;
      nPC_OPEN = npc;
      PA       = pa;
   endtask

   // One RUN-mode cycle with random loader noise, which must never write memory
   task automatic readCycle(input logic npc, input logic [7:0] pa);
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), npc, pa);
      tick();
      if (!npc) begin
         modelValid = 1'b1;
         modelInstr = modelMem[pa];
      end else begin
         modelValid = 1'b0;
      end
      checkOutput("instr_valid", 32'(INSTR_VALID), 32'(modelValid));
      checkOutput("instr", 32'(INSTR), 32'(modelInstr));
   endtask

   // Full load of the bytes in data; the load ends on LAST or when all 256 entries are filled
   task automatic doLoad(input logic [7:0] data[$], input bit useLast, input bit gaps);
      int n;
      int sum;
      n   = data.size();
      sum = 0;
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
      tick();
      modelValid = 1'b0;
      checkOutput("load_busy", 32'(BUSY), 32'd1);
      checkOutput("load_ready", 32'(LD_READY), 32'd1);
      checkOutput("load_count0", 32'(LD_COUNT), 32'd0);
      checkOutput("load_valid0", 32'(INSTR_VALID), 32'd0);
      for (int i = 0; i < n; i++) begin
         bit doneExp;
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               applyStimulus(1'b0, 1'b0, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
               tick();
               checkOutput("gap_count", 32'(LD_COUNT), 32'(i));
               checkOutput("gap_ready", 32'(LD_READY), 32'd1);
            end
         end
         applyStimulus(1'b0, 1'b1, data[i], 1'(useLast && (i == n - 1)), 1'($urandom_range(0, 1)), 8'($urandom));
         tick();
         modelMem[i[7:0]] = data[i];
         sum     += int'(data[i]);
         doneExp  = (i == n - 1);
         checkOutput("ld_count", 32'(LD_COUNT), 32'(i + 1));
         checkOutput("ld_done", 32'(LD_DONE), 32'(doneExp));
         checkOutput("busy", 32'(BUSY), 32'(!doneExp));
         checkOutput("ld_ready", 32'(LD_READY), 32'(!doneExp));
         checkOutput("valid_in_load", 32'(INSTR_VALID), 32'd0);
         checkOutput("instr_hold", 32'(INSTR), 32'(modelInstr));
`ifdef PROGMEM_CHKSUM_EN
         checkOutput("chksum", 32'(LD_CHKSUM), 32'(sum % 256));
`endif
      end
      // The LD_DONE cycle is already RUN, so a read presented here is serviced
      readCycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, n - 1)));
      checkOutput("done_pulse_end", 32'(LD_DONE), 32'd0);
      checkOutput("count_hold", 32'(LD_COUNT), 32'(n));
`ifdef PROGMEM_CHKSUM_EN
      checkOutput("chksum_hold", 32'(LD_CHKSUM), 32'(sum % 256));
`endif
   endtask

   // Main sequence
   initial begin
      numCompared   = 0;
      numMismatched = 0;
      modelInstr    = 8'h00;
      modelValid    = 1'b0;
      RST = 1'b1;
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
      tick();
      tick();
      checkOutput("rst_instr", 32'(INSTR), 32'h00);
      checkOutput("rst_valid", 32'(INSTR_VALID), 32'd0);
      checkOutput("rst_ready", 32'(LD_READY), 32'd0);
      checkOutput("rst_busy", 32'(BUSY), 32'd0);
      checkOutput("rst_count", 32'(LD_COUNT), 32'd0);
      checkOutput("rst_done", 32'(LD_DONE), 32'd0);
      RST = 1'b0;

      $display("[TB] short load");
      loadQ = '{8'hA1, 8'hB2, 8'hC3};
      doLoad(loadQ, 1'b1, 1'b0);
      readCycle(1'b0, 8'h02);
      checkOutput("short_read", 32'(INSTR), 32'hC3);

      $display("[TB] full-memory load");
      loadQ.delete();
      for (int i = 0; i < 256; i++) loadQ.push_back(8'(i));
      doLoad(loadQ, 1'b0, 1'b0);
      for (int p = 0; p < 256; p++) readCycle(1'b0, 8'(p));
      readCycle(1'b1, 8'h10);

      $display("[TB] random loads with handshake gaps");
      repeat (6) begin
         int n;
         n = $urandom_range(1, 40);
         loadQ.delete();
         for (int i = 0; i < n; i++) loadQ.push_back(8'($urandom));
         doLoad(loadQ, 1'b1, 1'b1);
         repeat (30) readCycle(1'($urandom_range(0, 1)), 8'($urandom));
      end

      $display("[TB] restart drops the coincident byte");
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
      tick();
      modelValid = 1'b0;
      applyStimulus(1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 8'h00);
      tick();
      modelMem[0] = 8'h11;
      applyStimulus(1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h00);
      tick();
      modelMem[1] = 8'h22;
      checkOutput("pre_restart_count", 32'(LD_COUNT), 32'd2);
      applyStimulus(1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 8'h00);
      tick();
      checkOutput("restart_count", 32'(LD_COUNT), 32'd0);
      checkOutput("restart_busy", 32'(BUSY), 32'd1);
      checkOutput("restart_done", 32'(LD_DONE), 32'd0);
`ifdef PROGMEM_CHKSUM_EN
      checkOutput("restart_chksum", 32'(LD_CHKSUM), 32'h00);
`endif
      applyStimulus(1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 8'h00);
      tick();
      modelMem[0] = 8'h44;
      checkOutput("restart_done1", 32'(LD_DONE), 32'd1);
      checkOutput("restart_count1", 32'(LD_COUNT), 32'd1);
      readCycle(1'b0, 8'h00);
      readCycle(1'b0, 8'h01);

      $display("[TB] reset aborts a load");
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
      tick();
      modelValid = 1'b0;
      applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 8'h00);
      tick();
      modelMem[0] = 8'h55;
      applyStimulus(1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 8'h00);
      tick();
      modelMem[1] = 8'h66;
      RST = 1'b1;
      applyStimulus(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 8'h00);
      tick();
      RST = 1'b0;
      modelInstr = 8'h00;
      modelValid = 1'b0;
      checkOutput("abort_done", 32'(LD_DONE), 32'd0);
      checkOutput("abort_busy", 32'(BUSY), 32'd0);
      checkOutput("abort_ready", 32'(LD_READY), 32'd0);
      checkOutput("abort_count", 32'(LD_COUNT), 32'd0);
      checkOutput("abort_instr", 32'(INSTR), 32'h00);
      readCycle(1'b0, 8'h00);
      readCycle(1'b0, 8'h01);
      readCycle(1'b0, 8'h02);
      readCycle(1'b1, 8'h00);
      readCycle(1'b1, 8'h01);

      $display("[TB] checksum load");
      loadQ = '{8'hF0, 8'h20};
      doLoad(loadQ, 1'b1, 1'b1);
`ifdef PROGMEM_CHKSUM_EN
      checkOutput("chksum_f0_20", 32'(LD_CHKSUM), 32'h10);
`endif
      readCycle(1'b0, 8'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

   // Global guard so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
